seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/mul_pkg.sv | 27 ++
 rtl/seq_multiplier.sv | 112 +++++++++++
 2 files changed

// File: rtl/mul_pkg.sv
// ============================================================================
// Module  : mul_pkg
// Brief   : Shared types for the sequential RV32M-style multiplier.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mul_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module  : seq_multiplier
// Brief   : Radix-2 shift-add 32x32 multiplier (MUL/MULH/MULHSU/MULHU).
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_multiplier
    import mul_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  result,
    output logic             done,
    output logic             busy
);

    state_e              r_state;
    state_e              w_next;
    op_e                 r_op;
    logic                r_neg;
    logic                r_zero;
    logic [4:0]          r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [XLEN-1:0]     r_result;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic [2*XLEN-1:0]   w_addend;
    logic [2*XLEN-1:0]   w_prod;

    // Magnitudes are unsigned, so -0x80000000 correctly yields 2^31.
    assign w_a_neg  = a[XLEN-1] && ((op == OP_MULH) || (op == OP_MULHSU));
    assign w_b_neg  = b[XLEN-1] && (op == OP_MULH);
    assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_prod   = r_neg ? (~r_acc + 1'b1) : r_acc;

    assign result = r_result;
    assign done   = (r_state == ST_IDLE);
    assign busy   = ~done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (en) w_next = ST_RUN;
            ST_RUN: begin
                if (r_zero)              w_next = ST_IDLE;
                else if (r_cnt == 5'd31) w_next = ST_FIX;
            end
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_op     <= op_e'(op);
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_zero   <= (a == '0) || (b == '0);
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                    end
                end
                ST_RUN: begin
                    // A zero operand spends one cycle here and bypasses the adder.
                    if (r_zero) begin
                        r_result <= '0;
                    end else begin
                        r_acc    <= r_acc + w_addend;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 5'd1;
                    end
                end
                ST_FIX: begin
                    r_result <= (r_op == OP_MUL) ? w_prod[XLEN-1:0]
                                                 : w_prod[2*XLEN-1:XLEN];
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
